// File: rtl/fft_mag_streamer_pkg.sv
// Shared types for the FFT magnitude streamer.
`include "fft_params.vh"

package fft_mag_streamer_pkg;

    localparam int MAG_W = 32;

    typedef enum logic [1:0] {
        IDLE  = `FFT_ST_IDLE,
        FILL  = `FFT_ST_FILL,
        BURST = `FFT_ST_BURST,
        GAP   = `FFT_ST_GAP
    } state_t;

endpackage

// File: rtl/fft_params.vh
// Shared FFT sizing defaults and state encodings for the magnitude streamer.
`ifndef FFT_PARAMS_VH
`define FFT_PARAMS_VH

`define FFT_WIDTH_DEFAULT       16
`define FFT_WIDTH_LOG_2_DEFAULT 4

`define FFT_ST_IDLE  2'd0
`define FFT_ST_FILL  2'd1
`define FFT_ST_BURST 2'd2
`define FFT_ST_GAP   2'd3

`endif

// File: rtl/mag_ram.sv
// Frame buffer: one write port, one registered read port, no reset on contents.
module mag_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/fft_mag_streamer.sv
// Collects the lower half of an FFT frame as squared magnitudes and
// replays it as one contiguous enable window for a peak finder.
`include "fft_params.vh"

module fft_mag_streamer
    import fft_mag_streamer_pkg::*;
#(
    parameter int FFT_WIDTH       = `FFT_WIDTH_DEFAULT,
    parameter int FFT_WIDTH_LOG_2 = `FFT_WIDTH_LOG_2_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic               in_sop,
    input  logic signed [15:0] in_real,
    input  logic signed [15:0] in_imag,
    output logic               in_ready,
    output logic               enable,
    output logic [MAG_W-1:0]   amplitude
);

    localparam int HALF = FFT_WIDTH / 2;
    localparam int IW   = FFT_WIDTH_LOG_2;
    localparam int AW   = FFT_WIDTH_LOG_2 - 1;

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_nidx;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_rd_addr;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    r_mag_addr;
    logic             r_mag_vld;
    logic [MAG_W-1:0] r_mag;
    logic [MAG_W-1:0] w_mag;
    logic [MAG_W-1:0] w_rd_data;
    logic signed [31:0] w_re_x;
    logic signed [31:0] w_im_x;
    logic signed [31:0] w_re2;
    logic signed [31:0] w_im2;
    logic w_acc;
    logic w_sop;
    logic w_fill_acc;
    logic w_last;
    logic w_store;

    assign in_ready   = (r_state == IDLE) || (r_state == FILL);
    assign w_acc      = in_valid && in_ready;
    assign w_sop      = w_acc && in_sop;
    assign w_fill_acc = w_acc && !in_sop && (r_state == FILL);
    assign w_nidx     = r_idx + 1'b1;
    assign w_last     = w_fill_acc && (&w_nidx);
    assign w_store    = w_sop || (w_fill_acc && !w_nidx[IW-1]);
    assign w_wr_addr  = in_sop ? '0 : w_nidx[AW-1:0];

    // Each square is at most 2^30, so the sum never exceeds 32 bits.
    assign w_re_x = 32'(in_real);
    assign w_im_x = 32'(in_imag);
    assign w_re2  = w_re_x * w_re_x;
    assign w_im2  = w_im_x * w_im_x;
    assign w_mag  = $unsigned(w_re2) + $unsigned(w_im2);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (w_sop) w_next = FILL;
            FILL:  if (w_last) w_next = BURST;
            BURST: if (r_cnt == AW'(HALF - 1)) w_next = GAP;
            GAP:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Read two ahead of the output so the RAM and output registers stay full.
    always_comb begin
        w_rd_addr = '0;
        if (r_state == BURST) begin
            w_rd_addr = r_cnt + AW'(2);
        end else if (w_last) begin
            w_rd_addr = AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_mag_vld  <= 1'b0;
            r_mag      <= '0;
            r_mag_addr <= '0;
            enable     <= 1'b0;
            amplitude  <= '0;
        end else begin
            r_state    <= w_next;
            r_mag_vld  <= w_store;
            r_mag      <= w_mag;
            r_mag_addr <= w_wr_addr;
            if (w_sop) begin
                r_idx <= '0;
            end else if (w_fill_acc) begin
                r_idx <= w_nidx;
            end
            r_cnt     <= (r_state == BURST) ? r_cnt + 1'b1 : '0;
            enable    <= (w_next == BURST);
            amplitude <= (w_next == BURST) ? w_rd_data : '0;
        end
    end

    mag_ram #(
        .DEPTH (HALF),
        .AW    (AW),
        .DW    (MAG_W)
    ) u_mag_ram (
        .clk       (clk),
        .i_wr_en   (r_mag_vld),
        .i_wr_addr (r_mag_addr),
        .i_wr_data (r_mag),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

endmodule

// File: doc/fft_mag_streamer.md
FFT_MAG_STREAMER -- requirements
Module: fft_mag_streamer

Interface
REQ-001 The block SHALL have parameter FFT_WIDTH, no default, FFT length in bins (power of two, >= 4).
REQ-002 The block SHALL have parameter FFT_WIDTH_LOG_2, no default, log2(FFT_WIDTH).
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  input bin present this cycle.
REQ-006 The block SHALL have port in_sop  input  1  marks bin 0 of a frame; qualified by in_valid.
REQ-007 The block SHALL have port in_real  input  16  signed real part of the bin.
REQ-008 The block SHALL have port in_imag  input  16  signed imaginary part of the bin.
REQ-009 The block SHALL have port in_ready  output  1  block accepts a bin when in_valid && in_ready.
REQ-010 The block SHALL have port enable  output  1  frame window for the peak finder; high for contiguous bins.
REQ-011 The block SHALL have port amplitude  output  32  unsigned squared magnitude of the current bin.

Function
REQ-012 The block SHALL implement states IDLE, FILL, BURST and GAP.
REQ-013 in_ready SHALL be 1 in IDLE and FILL and 0 in BURST and GAP, decoded from the state register.
REQ-014 In IDLE, an accepted bin with in_sop=1 SHALL be stored as bin 0 and move the state to FILL; accepted bins with in_sop=0 SHALL be discarded.
REQ-015 In FILL, each accepted bin SHALL increment the FFT_WIDTH_LOG_2-bit bin index; bins with index < FFT_WIDTH/2 SHALL be stored, all others discarded.
REQ-016 An accepted bin with in_sop=1 while in FILL SHALL restart the frame at index 0, and that bin SHALL be stored as bin 0.
REQ-017 Magnitude SHALL be computed as in_real^2 + in_imag^2 at full precision into 32 bits unsigned, with no truncation or saturation; the maximum is 32'h8000_0000.
REQ-018 Magnitude SHALL be registered one cycle after acceptance and then written to the frame buffer (FFT_WIDTH/2 x 32).
REQ-019 When bin FFT_WIDTH-1 is accepted, the state SHALL move to BURST on the cycle after the final buffer write completes.
REQ-020 In BURST, enable SHALL be 1 for exactly FFT_WIDTH/2 consecutive cycles, with no bubbles.
REQ-021 On the k-th enable-high cycle (k = 0..FFT_WIDTH/2-1), amplitude SHALL equal the stored magnitude of bin k.
REQ-022 enable and amplitude SHALL be registered together, and buffer read latency SHALL be hidden by prefetch.
REQ-023 After the last BURST cycle, the state SHALL be GAP for exactly 1 cycle with enable=0, so the downstream counter clears, and then return to IDLE.
REQ-024 While enable=0, amplitude SHALL hold 0.
REQ-025 in_valid while in_ready=0 SHALL have no effect; the upstream holds data.

Reset
REQ-026 reset_n=0 at a clock edge SHALL force state IDLE, bin index 0, enable 0, amplitude 0 and the magnitude pipeline invalid, from any state including mid-FILL or mid-BURST.
REQ-027 Frame buffer contents SHALL NOT be reset, and SHALL never be output before being rewritten in the current frame.
REQ-028 in_ready SHALL be 1 on the first cycle after the reset edge (state IDLE).

Structure
REQ-029 FFT_WIDTH/FFT_WIDTH_LOG_2 defaults used by the system and the state encodings SHALL live in shared header fft_params.vh with an include guard.
REQ-030 The frame buffer SHALL be a sub-module mag_ram: single clock, one write port and one registered read port, FFT_WIDTH/2 x 32.
REQ-031 The implementation SHALL be 120-400 lines of RTL excluding mag_ram.

Verification (FFT_WIDTH=16, FFT_WIDTH_LOG_2=4)
REQ-032 Frame bins k=0..15 with in_real=k, in_imag=0, sop on k=0 -> enable high 8 cycles with amplitudes 0,1,4,9,16,25,36,49, then enable low for 1 cycle.
REQ-033 Bin 3 with in_real=in_imag=-32768 and all other bins 0 -> the 4th enable cycle shows 32'h8000_0000; a downstream max instance reports frequency 3*24000/16384 = 4.
REQ-034 sop at k=0, then in_sop=1 again on the 6th bin, then 15 more bins with in_real=2 -> all 8 amplitudes equal 4; the first 5 bins are never output.
REQ-035 Random in_valid gaps during FILL -> the BURST output is still 8 contiguous enable cycles with correct values; in_ready=0 from BURST through GAP.
REQ-036 reset_n=0 on the 3rd BURST cycle -> the next cycle has enable=0, amplitude=0, in_ready=1; a following full frame streams correctly.
REQ-037 Bins without sop while in IDLE -> discarded and no enable pulse; back-to-back frames -> each produces exactly one 8-cycle enable window separated by at least 1 low cycle.
